// File: rtl/as_pack.sv
// Shared encodings for the as_ core: multicycle control states, opcodes and
// datapath mux/ALU select values.
package as_pack;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRPC
  } mc_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/as_mc_aludec.sv
// func3/func7b5 to ALU operation decode, with the supported-func3 check used
// by both the multicycle and single-cycle control.
module as_mc_aludec
  import as_pack::*;
(
  input  logic [2:0] func3_i,
  input  logic       func7b5_i,
  input  logic       is_r_i,
  output logic [2:0] alu_sel_o,
  output logic       supported_o
);

  always_comb begin
    alu_sel_o   = ALU_ADD;
    supported_o = 1'b1;
    case (func3_i)
      3'b000:  alu_sel_o = (is_r_i && func7b5_i) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_sel_o = ALU_SLT;
      3'b100:  alu_sel_o = ALU_XOR;
      3'b110:  alu_sel_o = ALU_OR;
      3'b111:  alu_sel_o = ALU_AND;
      default: supported_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/as_mc_control.sv
// Multicycle control FSM for the RV64I core: sequences the shared memory port
// and the single ALU, stalling on the memory ready/valid handshake.
module as_mc_control
  import as_pack::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic       func7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_wr_o,
  output logic       adr_src_o,
  output logic       ir_wr_o,
  output logic       pc_wr_o,
  output logic       reg_wr_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [1:0] imm_src_o,
  output logic [2:0] alu_sel_o,
  output logic       illegal_o,
  output logic       fault_o
);

  localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  mc_state_t     state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          mem_state, timeout;
  logic [2:0]    dec_alu_sel;
  logic          dec_supported;

  as_mc_aludec u_aludec (
    .func3_i     (func3_i),
    .func7b5_i   (func7b5_i),
    .is_r_i      (state == S_EXECR),
    .alu_sel_o   (dec_alu_sel),
    .supported_o (dec_supported)
  );

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout   = (MEM_TIMEOUT != 0) && mem_state && (wait_cnt == TMO);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      // Counter only runs while stalled in a memory state; any exit or timeout clears it.
      if ((MEM_TIMEOUT != 0) && mem_state && !mem_ready_i && !timeout)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    state_next   = state;
    mem_req_o    = 1'b0;
    mem_wr_o     = 1'b0;
    adr_src_o    = 1'b0;
    ir_wr_o      = 1'b0;
    pc_wr_o      = 1'b0;
    reg_wr_o     = 1'b0;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_B;
    result_src_o = RES_ALUOUT;
    imm_src_o    = IMM_I;
    alu_sel_o    = ALU_ADD;
    illegal_o    = 1'b0;
    fault_o      = timeout;
    case (state)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALU;
        ir_wr_o      = mem_ready_i && !timeout;
        pc_wr_o      = mem_ready_i && !timeout;
        if (!timeout && mem_ready_i) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = IMM_B;
        state_next  = S_FETCH;
        case (opcode_i)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:    if (dec_supported) state_next = S_EXECR; else illegal_o = 1'b1;
          OP_I:    if (dec_supported) state_next = S_EXECI; else illegal_o = 1'b1;
          OP_BR:   if (func3_i[2:1] == 2'b00) state_next = S_BRANCH; else illegal_o = 1'b1;
          OP_JAL:  state_next = S_JAL;
          OP_JALR: state_next = S_JALR;
          default: illegal_o = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = (opcode_i == OP_STORE) ? IMM_S : IMM_I;
        state_next  = (opcode_i == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (timeout) state_next = S_FETCH;
        else if (mem_ready_i) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = RES_DATA;
        reg_wr_o     = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_wr_o  = 1'b1;
        adr_src_o = 1'b1;
        if (timeout || mem_ready_i) state_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = (state == S_EXECR) ? SRCB_B : SRCB_IMM;
        alu_sel_o   = dec_alu_sel;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr_o   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = SRCA_A;
        alu_sel_o   = ALU_SUB;
        pc_wr_o     = func3_i[0] ? !zero_i : zero_i;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_wr_o     = 1'b1;
        state_next  = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a_o  = SRCA_OLDPC;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALU;
        reg_wr_o     = 1'b1;
        state_next   = S_JALRPC;
      end
      S_JALRPC: begin
        alu_src_a_o  = SRCA_A;
        alu_src_b_o  = SRCB_IMM;
        result_src_o = RES_ALU;
        pc_wr_o      = 1'b1;
        state_next   = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
    if (rst_i) begin
      mem_req_o    = 1'b0;
      mem_wr_o     = 1'b0;
      adr_src_o    = 1'b0;
      ir_wr_o      = 1'b0;
      pc_wr_o      = 1'b0;
      reg_wr_o     = 1'b0;
      alu_src_a_o  = '0;
      alu_src_b_o  = '0;
      result_src_o = '0;
      imm_src_o    = '0;
      alu_sel_o    = '0;
      illegal_o    = 1'b0;
      fault_o      = 1'b0;
    end
  end

endmodule

// File: tb/tb_as_mc_control.sv
// Bench for as_mc_control: per-instruction expected output sequences built from
// the instruction class, replayed cycle by cycle and compared against the DUT.
module tb_as_mc_control;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_wr;
    logic       adr_src;
    logic       ir_wr;
    logic       pc_wr;
    logic       reg_wr;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       illegal;
    logic       fault;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       zero;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    outs_t      exp;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1, zero = 1'b0, mem_ready = 1'b0, func7b5 = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic mem_req, mem_wr, adr_src, ir_wr, pc_wr, reg_wr, illegal, fault;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_sel;

  int checks = 0;
  int errors = 0;

  step_t stim[$];
  string names[$];
  outs_t chk_exp[$];
  string chk_name[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7, cur_zero;

  always #5 clk = ~clk;

  as_mc_control #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .func3_i(func3),
    .func7b5_i(func7b5), .zero_i(zero), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_wr_o(mem_wr), .adr_src_o(adr_src),
    .ir_wr_o(ir_wr), .pc_wr_o(pc_wr), .reg_wr_o(reg_wr),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .result_src_o(result_src), .imm_src_o(imm_src), .alu_sel_o(alu_sel),
    .illegal_o(illegal), .fault_o(fault)
  );

  // Per-state output tables taken from the operation description.
  function automatic outs_t o_fetch(logic rdy);
    outs_t o = '0;
    o.mem_req = 1'b1; o.b = 2'b10; o.res = 2'b10; o.ir_wr = rdy; o.pc_wr = rdy;
    return o;
  endfunction
  function automatic outs_t o_decode(logic ill);
    outs_t o = '0;
    o.a = 2'b01; o.b = 2'b01; o.imm = 2'b10; o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t o_memadr(logic store);
    outs_t o = '0;
    o.a = 2'b10; o.b = 2'b01; o.imm = store ? 2'b01 : 2'b00;
    return o;
  endfunction
  function automatic outs_t o_memacc(logic wr);
    outs_t o = '0;
    o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_wr = wr;
    return o;
  endfunction
  function automatic outs_t o_exec(logic r, logic [2:0] f3, logic f7);
    outs_t o = '0;
    o.a = 2'b10; o.b = r ? 2'b00 : 2'b01;
    case (f3)
      3'b000:  o.alu = (r && f7) ? 3'b001 : 3'b000;
      3'b010:  o.alu = 3'b101;
      3'b100:  o.alu = 3'b100;
      3'b110:  o.alu = 3'b011;
      default: o.alu = 3'b010;
    endcase
    return o;
  endfunction
  function automatic outs_t o_wb(logic [1:0] res);
    outs_t o = '0;
    o.res = res; o.reg_wr = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_branch(logic [2:0] f3, logic z);
    outs_t o = '0;
    o.a = 2'b10; o.alu = 3'b001; o.pc_wr = (f3 == 3'b000) ? z : !z;
    return o;
  endfunction
  function automatic outs_t o_link(logic jalr);
    outs_t o = '0;
    o.a = 2'b01; o.b = 2'b10;
    if (jalr) begin o.res = 2'b10; o.reg_wr = 1'b1; end
    else o.pc_wr = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_jalrpc();
    outs_t o = '0;
    o.a = 2'b10; o.b = 2'b01; o.res = 2'b10; o.pc_wr = 1'b1;
    return o;
  endfunction

  function automatic bit legal(logic [6:0] op, logic [2:0] f3);
    case (op)
      T_R, T_I: return f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
      T_BR:     return f3 inside {3'b000, 3'b001};
      T_LOAD, T_STORE, T_JAL, T_JALR: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic push(logic r, logic rdy, outs_t e, string nm);
    step_t s;
    s.rst = r; s.rdy = rdy; s.zero = cur_zero; s.op = cur_op;
    s.f3 = cur_f3; s.f7 = cur_f7; s.exp = e;
    stim.push_back(s);
    names.push_back(nm);
  endtask

  task automatic instr(string nm, logic [6:0] op, logic [2:0] f3, logic f7,
                       logic z, int fw, int mw);
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_zero = z;
    for (int i = 0; i < fw; i++) push(1'b0, 1'b0, o_fetch(1'b0), {nm, ".fetchwait"});
    push(1'b0, 1'b1, o_fetch(1'b1), {nm, ".fetch"});
    if (!legal(op, f3)) begin
      push(1'b0, 1'b1, o_decode(1'b1), {nm, ".decode"});
      return;
    end
    push(1'b0, 1'b1, o_decode(1'b0), {nm, ".decode"});
    case (op)
      T_LOAD: begin
        push(1'b0, 1'b1, o_memadr(1'b0), {nm, ".memadr"});
        for (int i = 0; i < mw; i++) push(1'b0, 1'b0, o_memacc(1'b0), {nm, ".memwait"});
        push(1'b0, 1'b1, o_memacc(1'b0), {nm, ".memrd"});
        push(1'b0, 1'b1, o_wb(2'b01), {nm, ".memwb"});
      end
      T_STORE: begin
        push(1'b0, 1'b1, o_memadr(1'b1), {nm, ".memadr"});
        for (int i = 0; i < mw; i++) push(1'b0, 1'b0, o_memacc(1'b1), {nm, ".memwait"});
        push(1'b0, 1'b1, o_memacc(1'b1), {nm, ".memwr"});
      end
      T_R, T_I: begin
        push(1'b0, 1'b1, o_exec(op == T_R, f3, f7), {nm, ".exec"});
        push(1'b0, 1'b1, o_wb(2'b00), {nm, ".aluwb"});
      end
      T_BR: push(1'b0, 1'b1, o_branch(f3, z), {nm, ".branch"});
      T_JAL: begin
        push(1'b0, 1'b1, o_link(1'b0), {nm, ".jal"});
        push(1'b0, 1'b1, o_wb(2'b00), {nm, ".aluwb"});
      end
      default: begin
        push(1'b0, 1'b1, o_link(1'b1), {nm, ".jalr"});
        push(1'b0, 1'b1, o_jalrpc(), {nm, ".jalrpc"});
      end
    endcase
  endtask

  task automatic pin(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Single compare process: checks every driven cycle away from the clock edge.
  initial begin
    outs_t act, e;
    string nm;
    forever begin
      @(negedge clk);
      #2;
      if (chk_exp.size() > 0) begin
        e  = chk_exp.pop_front();
        nm = chk_name.pop_front();
        act = {mem_req, mem_wr, adr_src, ir_wr, pc_wr, reg_wr, alu_src_a,
               alu_src_b, result_src, imm_src, alu_sel, illegal, fault};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    outs_t o;
    cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0; cur_zero = 1'b0;
    push(1'b1, 1'b0, '0, "reset");
    push(1'b1, 1'b1, '0, "reset");

    n0 = stim.size(); instr("add", T_R, 3'b000, 1'b0, 1'b0, 0, 0);
    pin("add.cycles", stim.size() - n0, 4);
    pin("add.reg_wr_c4", int'(stim[n0 + 3].exp.reg_wr), 1);
    n0 = stim.size(); instr("sub", T_R, 3'b000, 1'b1, 1'b0, 0, 0);
    pin("sub.alu_sel", int'(stim[n0 + 2].exp.alu), 1);
    n0 = stim.size(); instr("lw", T_LOAD, 3'b010, 1'b0, 1'b0, 0, 2);
    pin("lw.cycles", stim.size() - n0, 7);
    pin("lw.memwb_res", int'(stim[n0 + 6].exp.res), 1);
    n0 = stim.size(); instr("sw", T_STORE, 3'b010, 1'b0, 1'b0, 1, 1);
    pin("sw.cycles", stim.size() - n0, 6);
    n0 = stim.size(); instr("beq_z1", T_BR, 3'b000, 1'b0, 1'b1, 0, 0);
    pin("beq.cycles", stim.size() - n0, 3);
    pin("beq.pc_wr", int'(stim[n0 + 2].exp.pc_wr), 1);
    n0 = stim.size(); instr("bne_z1", T_BR, 3'b001, 1'b0, 1'b1, 0, 0);
    pin("bne.pc_wr", int'(stim[n0 + 2].exp.pc_wr), 0);
    instr("beq_z0", T_BR, 3'b000, 1'b0, 1'b0, 0, 0);
    instr("bne_z0", T_BR, 3'b001, 1'b0, 1'b0, 0, 0);
    n0 = stim.size(); instr("jal", T_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    pin("jal.cycles", stim.size() - n0, 4);
    n0 = stim.size(); instr("jalr", T_JALR, 3'b000, 1'b0, 1'b0, 0, 0);
    pin("jalr.res", int'(stim[n0 + 2].exp.res), 2);
    pin("jalrpc.src_a", int'(stim[n0 + 3].exp.a), 2);
    instr("xori", T_I, 3'b100, 1'b0, 1'b0, 0, 0);
    instr("addi_f7", T_I, 3'b000, 1'b1, 1'b0, 0, 0);
    instr("or", T_R, 3'b110, 1'b0, 1'b0, 0, 0);
    instr("and", T_R, 3'b111, 1'b0, 1'b0, 0, 0);
    instr("slt", T_R, 3'b010, 1'b0, 1'b0, 0, 0);
    n0 = stim.size(); instr("ill_op0", 7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
    pin("ill.cycles", stim.size() - n0, 2);
    instr("ill_i001", T_I, 3'b001, 1'b0, 1'b0, 0, 0);
    instr("ill_r101", T_R, 3'b101, 1'b0, 1'b0, 0, 0);
    instr("ill_br100", T_BR, 3'b100, 1'b0, 1'b0, 0, 0);

    // Load abandoned by a 3-cycle reset while waiting in MEMRD.
    cur_op = T_LOAD; cur_f3 = 3'b011; cur_f7 = 1'b0; cur_zero = 1'b0;
    push(1'b0, 1'b1, o_fetch(1'b1), "abort.fetch");
    push(1'b0, 1'b1, o_decode(1'b0), "abort.decode");
    push(1'b0, 1'b1, o_memadr(1'b0), "abort.memadr");
    push(1'b0, 1'b0, o_memacc(1'b0), "abort.memwait");
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, '0, "abort.reset");
    n0 = stim.size(); instr("post_rst", T_R, 3'b000, 1'b0, 1'b0, 0, 0);
    pin("post_rst.b_sel", int'(stim[n0].exp.b), 2);

    // Fetch timeout: four wait cycles, then a fault pulse with no write enables.
    cur_op = T_R; cur_f3 = 3'b000;
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, o_fetch(1'b0), "tmo.wait");
    o = o_fetch(1'b0); o.fault = 1'b1;
    push(1'b0, 1'b0, o, "tmo.fault");
    instr("post_tmo", T_I, 3'b111, 1'b0, 1'b0, 0, 0);

    foreach (stim[k]) begin
      @(negedge clk);
      rst = stim[k].rst; mem_ready = stim[k].rdy; zero = stim[k].zero;
      opcode = stim[k].op; func3 = stim[k].f3; func7b5 = stim[k].f7;
      chk_exp.push_back(stim[k].exp);
      chk_name.push_back(names[k]);
    end
    @(negedge clk);
    #4;
    pin("queue_drained", chk_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
